// File: rtl/byte_serial_add_ctrl_pkg.sv
// Shared types and constants for the byte-serial add/subtract controller.
package byte_serial_add_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte-index counter width; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/byte_serial_add_ctrl_if.sv
// Operation/result handshake bundle for the byte-serial add/subtract controller.
interface byte_serial_add_ctrl_if
    import byte_serial_add_ctrl_pkg::*;
#(
    parameter int unsigned N_BYTES = 4
);
    localparam int unsigned DW = BYTE_W * N_BYTES;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic          carry_out;
    logic          overflow;

    // Requester side: issues operations and consumes results.
    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow
    );

    // Controller side.
    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, result, carry_out, overflow
    );

endinterface

// File: rtl/RippleCarryAdder.sv
// 8-bit ripple-carry adder shared by the wide-accumulator sequencing logic.
module RippleCarryAdder (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] S,
    output logic       Cout
);
    logic [8:0] w_c;

    assign w_c[0] = Cin;

    for (genvar g = 0; g < 8; g++) begin : g_fa
        assign S[g]       = A[g] ^ B[g] ^ w_c[g];
        assign w_c[g + 1] = (A[g] & B[g]) | (w_c[g] & (A[g] ^ B[g]));
    end

    assign Cout = w_c[8];

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// Runs an N_BYTES-wide add/subtract through one 8-bit ripple-carry adder,
// one byte per clock, LSB first, with the carry chained through a register.
module byte_serial_add_ctrl
    import byte_serial_add_ctrl_pkg::*;
#(
    parameter int unsigned N_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    byte_serial_add_ctrl_if.slave bus
);
    localparam int unsigned     DW       = BYTE_W * N_BYTES;
    localparam int unsigned     IW       = idx_width(N_BYTES);
    localparam logic [IW-1:0]   LAST_IDX = IW'(N_BYTES - 1);

    state_t r_state;
    state_t w_state_nxt;

    // Operands held byte-addressable; r_b already carries the subtract inversion.
    logic [N_BYTES-1:0][BYTE_W-1:0] r_a;
    logic [N_BYTES-1:0][BYTE_W-1:0] r_b;
    logic [N_BYTES-1:0][BYTE_W-1:0] r_result;
    logic                           r_carry;
    logic [IW-1:0]                  r_idx;
    logic                           r_carry_out;
    logic                           r_overflow;

    logic              w_accept;
    logic              w_step;
    logic              w_last;
    logic              w_in_ready;
    logic              w_out_valid;
    logic [BYTE_W-1:0] w_add_a;
    logic [BYTE_W-1:0] w_add_b;
    logic [BYTE_W-1:0] w_sum;
    logic              w_cout;
    logic              w_ovf;

    assign w_add_a = r_a[r_idx];
    assign w_add_b = r_b[r_idx];

    RippleCarryAdder u_rca (
        .A    (w_add_a),
        .B    (w_add_b),
        .Cin  (r_carry),
        .S    (w_sum),
        .Cout (w_cout)
    );

    // Only meaningful on the final (most significant) byte.
    assign w_ovf = (w_add_a[BYTE_W-1] == w_add_b[BYTE_W-1]) &&
                   (w_sum[BYTE_W-1] != w_add_a[BYTE_W-1]);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state handshake/datapath controls.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, per-byte result write-back and final flag capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.op_a;
            r_b     <= bus.op_b ^ {DW{bus.sub}};
            r_carry <= (bus.sub == OP_SUB);
            r_idx   <= '0;
        end else if (w_step) begin
            r_result[r_idx] <= w_sum;
            r_carry         <= w_cout;
            if (w_last) begin
                r_idx       <= '0;
                r_carry_out <= w_cout;
                r_overflow  <= w_ovf;
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.carry_out = r_carry_out;
    assign bus.overflow  = r_overflow;

endmodule
